// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   DIV_WIDTH  default divisor/quotient/remainder width
//   DIV_CNT_W  step counter width for the default width (clog2(WIDTH)+1)
//   div_state_e  controller states
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   r_in     partial remainder (always < divisor, so WIDTH bits suffice)
//   divisor  denominator
//   bit_in   next dividend bit, MSB first
//   r_out    new partial remainder
//   qbit     quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] r_out,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {r_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        qbit    = (shifted >= {1'b0, divisor});
        // The difference is below divisor whenever it is taken, so it fits WIDTH bits.
        r_out   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, valid/ready on both sides.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    operand handshake (in_ready high only when idle)
//   dividend, divisor     operands, sampled on accept only
//   signed_op             two's-complement operation (only with DIV_SIGNED_EN)
//   out_valid, out_ready  result handshake
//   quotient, remainder   result, held while out_valid
//   div_by_zero, overflow exception flags
// Optional feature macro: DIV_SIGNED_EN (signed operation support).
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
`ifdef DIV_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned   CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e           state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   dvd_r;     // dividend as accepted (low half reused on overflow)
    logic [WIDTH-1:0]     dvs_r;     // divisor; replaced by its magnitude in CHECK
    logic [WIDTH-1:0]     part_r;    // partial remainder
    logic [WIDTH-1:0]     shreg;     // dividend low bits shift out, quotient bits shift in

    logic [2*WIDTH-1:0]   mag_dvd;
    logic [WIDTH-1:0]     mag_dvs;
    logic [WIDTH-1:0]     step_r;
    logic                 step_q;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     res_q;
    logic [WIDTH-1:0]     res_r;
    logic                 res_ovf;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
    logic sgn_r;
    logic neg_q_r;
    logic neg_r_r;
`endif

    assign in_ready = (state == S_IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (part_r),
        .divisor (dvs_r),
        .bit_in  (shreg[WIDTH-1]),
        .r_out   (step_r),
        .qbit    (step_q)
    );

    always_comb begin
        q_mag = {shreg[WIDTH-2:0], step_q};
`ifdef DIV_SIGNED_EN
        mag_dvd = (sgn_r && dvd_r[2*WIDTH-1]) ? (~dvd_r + 1'b1) : dvd_r;
        mag_dvs = (sgn_r && dvs_r[WIDTH-1])   ? (~dvs_r + 1'b1) : dvs_r;
        res_q   = neg_q_r ? (~q_mag + 1'b1)  : q_mag;
        res_r   = neg_r_r ? (~step_r + 1'b1) : step_r;
        // Negative results may reach -2^(W-1); positive ones must stay below 2^(W-1).
        if (sgn_r) begin
            res_ovf = neg_q_r ? (q_mag > MIN_MAG) : q_mag[WIDTH-1];
        end else begin
            res_ovf = 1'b0;
        end
        if (res_ovf) begin
            res_q = '1;
            res_r = dvd_r[WIDTH-1:0];
        end
`else
        mag_dvd = dvd_r;
        mag_dvs = dvs_r;
        res_q   = q_mag;
        res_r   = step_r;
        res_ovf = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            part_r      <= '0;
            shreg       <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_r       <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
`ifdef DIV_SIGNED_EN
                        sgn_r <= signed_op;
`endif
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    cnt    <= '0;
                    part_r <= mag_dvd[2*WIDTH-1:WIDTH];
                    shreg  <= mag_dvd[WIDTH-1:0];
                    dvs_r  <= mag_dvs;
`ifdef DIV_SIGNED_EN
                    neg_q_r <= sgn_r && (dvd_r[2*WIDTH-1] ^ dvs_r[WIDTH-1]);
                    neg_r_r <= sgn_r && dvd_r[2*WIDTH-1];
`endif
                    if (dvs_r == '0) begin
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dvd_r[WIDTH-1:0];
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (mag_dvd[2*WIDTH-1:WIDTH] >= mag_dvs) begin
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dvd_r[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    part_r <= step_r;
                    shreg  <= q_mag;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= 1'b0;
                        overflow    <= res_ovf;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           acc;
        int           lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           signed_op = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic hold = 1'b0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2*W-1:0] d, input logic [W-1:0] b, input logic s);
        exp_t           e;
        logic [2*W-1:0] md;
        logic [W-1:0]   mb;
        longint         sq;
        longint         sr;
        e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.acc = 0; e.lat = W + 1;
        md = (s && d[2*W-1]) ? -d : d;
        mb = (s && b[W-1]) ? -b : b;
        if (b == 0) begin
            e.dbz = 1'b1; e.q = '1; e.r = d[W-1:0]; e.lat = 1;
        end else if (md[2*W-1:W] >= mb) begin
            e.ovf = 1'b1; e.q = '1; e.r = d[W-1:0]; e.lat = 1;
        end else if (!s) begin
            e.q = W'(d / {{W{1'b0}}, b});
            e.r = W'(d % {{W{1'b0}}, b});
        end else begin
            sq = $signed(d) / longint'($signed(b));
            sr = $signed(d) % longint'($signed(b));
            if (sq > 64'sd2147483647 || sq < -64'sd2147483648) begin
                e.ovf = 1'b1; e.q = '1; e.r = d[W-1:0];
            end else begin
                e.q = W'(sq); e.r = W'(sr);
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz, input logic ovf, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Called just after a falling edge; the transfer happens on the next rising edge.
    task automatic issue(input logic [2*W-1:0] d, input logic [W-1:0] b, input logic s,
                         input exp_t e, input bit push);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            dividend  = d;
            divisor   = b;
            signed_op = s;
            in_valid  = 1'b1;
            e.acc     = cyc + 1;
            if (push) sb.push_back(e);
            @(negedge clk);
            in_valid  = 1'b0;
            dividend  = {$urandom, $urandom};
            divisor   = $urandom;
            signed_op = 1'($urandom);
        end
    endtask

    // Consumer back-pressure.
    always @(posedge clk) begin
        #1;
        if (hold) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: checks latency on each rising out_valid and contents on each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out_valid: actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                chk("overflow", 64'(overflow), 64'(e.ovf));
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   r;
        logic [2*W-1:0] d;
        logic           s;
        exp_t           e;
        int             t;

        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_quotient", 64'(quotient), 64'd0);
        chk("reset_remainder", 64'(remainder), 64'd0);
        chk("reset_flags", 64'({div_by_zero, overflow}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(64'h64, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 1'b0, 33), 1'b1);
        issue(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b0,
              mk(32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 1), 1'b1);
        issue(64'h0000_0007_0000_0000, 32'd7, 1'b0,
              mk(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1), 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 1'b0,
              mk(32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b0, 1'b1, 1), 1'b1);
        issue(64'h0000_0006_FFFF_FFFF, 32'd7, 1'b0,
              mk(32'hFFFF_FFFF, 32'd6, 1'b0, 1'b0, 33), 1'b1);
        issue(64'h0, 32'd1, 1'b0, mk(32'd0, 32'd0, 1'b0, 1'b0, 33), 1'b1);
        issue(64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              mk(32'd1, 32'd0, 1'b0, 1'b0, 33), 1'b1);

        // Round trip: dividend = a*b + r
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = $urandom_range(1, 255);
            if (b == 0) b = 32'd1;
            r = $urandom % b;
            d = 64'(a) * 64'(b) + 64'(r);
            issue(d, b, 1'b0, mk(a, r, 1'b0, 1'b0, 33), 1'b1);
        end

        // Random unsigned mix including exceptions
        for (int i = 0; i < 100; i++) begin
            b = (i % 10 == 0) ? 32'd0 : $urandom;
            d = {(i % 3 == 0) ? $urandom : ($urandom % (b | 32'd1)), $urandom};
            issue(d, b, 1'b0, model(d, b, 1'b0), 1'b1);
        end
        wait_drain();

        // Back-pressure: result held for 5 cycles
        hold = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        e = mk(32'd1234, 32'd56, 1'b0, 1'b0, 33);
        d = 64'(1234) * 64'd1000 + 64'd56;
        issue(d, 32'd1000, 1'b0, e, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_quotient", 64'(quotient), 64'(e.q));
            chk("hold_remainder", 64'(remainder), 64'(e.r));
            @(negedge clk);
        end
        hold = 1'b0;
        wait_drain();

        // Reset in the middle of RUN discards the operation
        issue(64'h0000_0001_0000_0000, 32'd3, 1'b0, e, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        end
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        issue(64'h64, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 1'b0, 33), 1'b1);
        wait_drain();

`ifdef DIV_SIGNED_EN
        issue(-64'sd100, 32'd7, 1'b1, mk(-32'sd14, -32'sd2, 1'b0, 1'b0, 33), 1'b1);
        issue(64'd100, -32'sd7, 1'b1, mk(-32'sd14, 32'd2, 1'b0, 1'b0, 33), 1'b1);
        issue(-64'sd100, -32'sd7, 1'b1, mk(32'd14, -32'sd2, 1'b0, 1'b0, 33), 1'b1);
        issue(64'h0000_0000_8000_0000, 32'd1, 1'b1,
              mk(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 33), 1'b1);
        issue(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1,
              mk(32'h8000_0000, 32'd0, 1'b0, 1'b0, 33), 1'b1);
        for (int i = 0; i < 100; i++) begin
            s = 1'($urandom);
            b = (i % 10 == 0) ? 32'd0 : $urandom;
            if (i % 2 == 0) b = W'($signed($urandom_range(0, 2000)) - 1000);
            d = {{32{1'b0}}, $urandom};
            if (i % 3 == 0) d = -d;
            issue(d, b, s, model(d, b, s), 1'b1);
        end
        wait_drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
